// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter (fetch read-only, mem-stage read/write) onto a single pulse-handshake
// memory bus with one outstanding transaction, per-port pending slots and round-robin ties.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  f_request_enable,
    input  logic [ADDR_W-1:0]     f_addr,
    output logic                  f_response_enable,
    output logic [DATA_W-1:0]     f_data,
    input  logic                  m_request_enable,
    input  logic                  m_mode,
    input  logic [ADDR_W-1:0]     m_addr,
    input  logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_response_enable,
    output logic [DATA_W-1:0]     m_data,
    output logic                  bus_request_enable,
    output logic                  bus_mode,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    input  logic                  bus_response_enable,
    input  logic [DATA_W-1:0]     bus_data,
    output logic                  busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic FETCH = 1'b0;
    localparam logic MEM   = 1'b1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q;
    logic                owner_q;
    logic                last_q;

    logic                fp_q;
    logic [ADDR_W-1:0]   fp_addr_q;
    logic                mp_q;
    logic                mp_mode_q;
    logic [ADDR_W-1:0]   mp_addr_q;
    logic [DATA_W-1:0]   mp_wdata_q;
    logic [STRB_W-1:0]   mp_wstrb_q;

    logic resp, can_grant, grant, gnt_mem;
    logic f_drop, m_drop, f_live, m_live, f_cand, m_cand;
    logic                f_addr_sel;
    logic [ADDR_W-1:0]   f_addr_d;
    logic                m_mode_d;
    logic [ADDR_W-1:0]   m_addr_d;
    logic [DATA_W-1:0]   m_wdata_d;
    logic [STRB_W-1:0]   m_wstrb_d;

    assign resp      = (state_q == WAIT) && bus_response_enable;
    assign can_grant = (state_q == IDLE) || bus_response_enable;

    // The owner may re-request on the very edge its response arrives; otherwise a
    // pulse from a port already pending or owning the bus is a protocol violation.
    assign f_drop = f_request_enable &&
                    (fp_q || (state_q == WAIT && owner_q == FETCH && !bus_response_enable));
    assign m_drop = m_request_enable &&
                    (mp_q || (state_q == WAIT && owner_q == MEM && !bus_response_enable));
    assign f_live = f_request_enable && !f_drop;
    assign m_live = m_request_enable && !m_drop;
    assign f_cand = fp_q || f_live;
    assign m_cand = mp_q || m_live;

    assign gnt_mem = m_cand && (!f_cand || last_q == FETCH);
    assign grant   = can_grant && (f_cand || m_cand);

    assign f_addr_sel = fp_q;
    assign f_addr_d   = f_addr_sel ? fp_addr_q  : f_addr;
    assign m_mode_d   = mp_q       ? mp_mode_q  : m_mode;
    assign m_addr_d   = mp_q       ? mp_addr_q  : m_addr;
    assign m_wdata_d  = mp_q       ? mp_wdata_q : m_wdata;
    assign m_wstrb_d  = mp_q       ? mp_wstrb_q : m_wstrb;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q            <= IDLE;
            owner_q            <= FETCH;
            last_q             <= FETCH;
            fp_q               <= 1'b0;
            fp_addr_q          <= '0;
            mp_q               <= 1'b0;
            mp_mode_q          <= 1'b0;
            mp_addr_q          <= '0;
            mp_wdata_q         <= '0;
            mp_wstrb_q         <= '0;
            f_response_enable  <= 1'b0;
            f_data             <= '0;
            m_response_enable  <= 1'b0;
            m_data             <= '0;
            bus_request_enable <= 1'b0;
            bus_mode           <= 1'b0;
            bus_addr           <= '0;
            bus_wdata          <= '0;
            bus_wstrb          <= '0;
            busy               <= 1'b0;
        end else begin
            bus_request_enable <= grant;
            f_response_enable  <= resp && (owner_q == FETCH);
            m_response_enable  <= resp && (owner_q == MEM);
            if (resp && owner_q == FETCH) f_data <= bus_data;
            if (resp && owner_q == MEM)   m_data <= bus_data;

            if (grant) begin
                state_q <= WAIT;
                owner_q <= gnt_mem;
                last_q  <= gnt_mem;
                busy    <= 1'b1;
                if (gnt_mem) begin
                    bus_mode  <= m_mode_d;
                    bus_addr  <= m_addr_d;
                    bus_wdata <= m_wdata_d;
                    bus_wstrb <= m_wstrb_d;
                end else begin
                    bus_mode  <= 1'b0;
                    bus_addr  <= f_addr_d;
                    bus_wdata <= '0;
                    bus_wstrb <= '0;
                end
            end else if (resp) begin
                state_q <= IDLE;
                busy    <= 1'b0;
            end

            // A candidate that lost (or could not be issued) stays in its slot.
            fp_q <= f_cand && !(grant && !gnt_mem);
            mp_q <= m_cand && !(grant && gnt_mem);
            if (f_live) fp_addr_q <= f_addr;
            if (m_live) begin
                mp_mode_q  <= m_mode;
                mp_addr_q  <= m_addr;
                mp_wdata_q <= m_wdata;
                mp_wstrb_q <= m_wstrb;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!f_drop);
            assert (!m_drop);
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the two-port arbitration rules.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        f_request_enable;
    logic [31:0] f_addr;
    logic        f_response_enable;
    logic [31:0] f_data;
    logic        m_request_enable;
    logic        m_mode;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_response_enable;
    logic [31:0] m_data;
    logic        bus_request_enable;
    logic        bus_mode;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_response_enable;
    logic [31:0] bus_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .f_request_enable(f_request_enable), .f_addr(f_addr),
        .f_response_enable(f_response_enable), .f_data(f_data),
        .m_request_enable(m_request_enable), .m_mode(m_mode), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_response_enable(m_response_enable), .m_data(m_data),
        .bus_request_enable(bus_request_enable), .bus_mode(bus_mode), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_response_enable(bus_response_enable), .bus_data(bus_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: each port has at most one waiting request; whoever holds the bus
    // is 'own' (-1 none, 0 fetch, 1 mem); ties go to the port that did not win last.
    int          own = -1;
    int          last = 0;
    bit          fpend = 0, mpend = 0;
    logic [31:0] fpa, mpa, mpw;
    logic        mpm;
    logic [3:0]  mps;
    logic        exp_breq = 0, exp_fr = 0, exp_mr = 0, exp_busy = 0, exp_bmode = 0;
    logic [31:0] exp_baddr = 0, exp_bwdata = 0, exp_fdata = 0, exp_mdata = 0;
    logic [3:0]  exp_bwstrb = 0;

    task automatic model_step();
        int pick;
        if (!rstn) begin
            own = -1; last = 0; fpend = 0; mpend = 0;
            exp_breq = 0; exp_fr = 0; exp_mr = 0; exp_busy = 0; exp_bmode = 0;
            exp_baddr = 0; exp_bwdata = 0; exp_bwstrb = 0; exp_fdata = 0; exp_mdata = 0;
            return;
        end
        exp_breq = 0; exp_fr = 0; exp_mr = 0;
        if (own >= 0 && bus_response_enable) begin
            if (own == 0) begin exp_fr = 1; exp_fdata = bus_data; end
            else          begin exp_mr = 1; exp_mdata = bus_data; end
            own = -1;
        end
        if (f_request_enable) begin fpend = 1; fpa = f_addr; end
        if (m_request_enable) begin
            mpend = 1; mpa = m_addr; mpm = m_mode; mpw = m_wdata; mps = m_wstrb;
        end
        if (own < 0 && (fpend || mpend)) begin
            pick = (fpend && mpend) ? 1 - last : (mpend ? 1 : 0);
            exp_breq = 1; own = pick; last = pick;
            if (pick == 1) begin
                exp_bmode = mpm; exp_baddr = mpa; exp_bwdata = mpw; exp_bwstrb = mps; mpend = 0;
            end else begin
                exp_bmode = 0; exp_baddr = fpa; exp_bwdata = 0; exp_bwstrb = 0; fpend = 0;
            end
        end
        exp_busy = (own >= 0);
    endtask

    always @(posedge clk) model_step();

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        f_request_enable = 0; m_request_enable = 0; bus_response_enable = 0;
    endtask

    task automatic test_reset();
        rstn = 0; clr();
        f_addr = 0; m_mode = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; bus_data = 0;
        tick(); tick();
        checks++;
        if ({bus_request_enable, busy, f_response_enable, m_response_enable, bus_mode} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000",
                {bus_request_enable, busy, f_response_enable, m_response_enable, bus_mode});
        end
        checks++;
        if ({bus_addr, bus_wdata, bus_wstrb, f_data, m_data} !== 132'b0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h %h want all 0",
                bus_addr, bus_wdata, bus_wstrb, f_data, m_data);
        end
        rstn = 1;
    endtask

    task automatic test_single_fetch();
        f_request_enable = 1; f_addr = 32'h1000;
        tick(); clr();
        checks++;
        if ({bus_request_enable, bus_mode, busy} !== 3'b101 || bus_addr !== 32'h1000) begin
            errors++; $display("FAIL single_issue got req=%b mode=%b busy=%b addr=%h want 1 0 1 00001000",
                bus_request_enable, bus_mode, busy, bus_addr);
        end
        tick();
        checks++;
        if (bus_request_enable !== 0 || busy !== 1) begin
            errors++; $display("FAIL single_req_pulse got req=%b busy=%b want 0 1", bus_request_enable, busy);
        end
        tick();
        bus_response_enable = 1; bus_data = 32'hDEADBEEF;
        tick(); clr();
        checks++;
        if ({f_response_enable, m_response_enable, busy} !== 3'b100 || f_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_resp got fr=%b mr=%b busy=%b data=%h want 1 0 0 deadbeef",
                f_response_enable, m_response_enable, busy, f_data);
        end
        tick();
        checks++;
        if (f_response_enable !== 0 || f_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_hold got fr=%b data=%h want 0 deadbeef", f_response_enable, f_data);
        end
    endtask

    task automatic test_simultaneous();
        rstn = 0; tick(); rstn = 1;
        f_request_enable = 1; f_addr = 32'h2000;
        m_request_enable = 1; m_mode = 1; m_addr = 32'h3000; m_wdata = 32'h11223344; m_wstrb = 4'hF;
        tick(); clr();
        checks++;
        if (bus_request_enable !== 1 || bus_mode !== 1 || bus_addr !== 32'h3000 ||
            bus_wdata !== 32'h11223344 || bus_wstrb !== 4'hF) begin
            errors++; $display("FAIL simul_mem_first got req=%b mode=%b addr=%h wd=%h st=%h want 1 1 3000 11223344 f",
                bus_request_enable, bus_mode, bus_addr, bus_wdata, bus_wstrb);
        end
        tick();
        bus_response_enable = 1; bus_data = 32'hA5A5A5A5;
        tick(); clr();
        checks++;
        if ({m_response_enable, bus_request_enable, busy, bus_mode} !== 4'b1110 ||
            m_data !== 32'hA5A5A5A5 || bus_addr !== 32'h2000 || bus_wstrb !== 4'h0) begin
            errors++; $display("FAIL simul_b2b got mr=%b req=%b busy=%b mode=%b md=%h addr=%h st=%h want 1 1 1 0 a5a5a5a5 2000 0",
                m_response_enable, bus_request_enable, busy, bus_mode, m_data, bus_addr, bus_wstrb);
        end
        bus_response_enable = 1; bus_data = 32'h00000077;
        tick(); clr();
        checks++;
        if ({f_response_enable, m_response_enable, busy} !== 3'b100 || f_data !== 32'h77) begin
            errors++; $display("FAIL simul_fetch_resp got fr=%b mr=%b busy=%b fd=%h want 1 0 0 77",
                f_response_enable, m_response_enable, busy, f_data);
        end
    endtask

    task automatic test_round_robin();
        m_request_enable = 1; m_mode = 0; m_addr = 32'h500; m_wdata = 0; m_wstrb = 0;
        tick(); clr();
        bus_response_enable = 1; bus_data = 32'h1;
        tick(); clr();
        f_request_enable = 1; f_addr = 32'h600;
        m_request_enable = 1; m_addr = 32'h700;
        tick(); clr();
        checks++;
        if (bus_request_enable !== 1 || bus_addr !== 32'h600) begin
            errors++; $display("FAIL rr_fetch_first got req=%b addr=%h want 1 600", bus_request_enable, bus_addr);
        end
        bus_response_enable = 1; bus_data = 32'h2;
        tick(); clr();
        checks++;
        if ({f_response_enable, bus_request_enable} !== 2'b11 || bus_addr !== 32'h700) begin
            errors++; $display("FAIL rr_mem_second got fr=%b req=%b addr=%h want 1 1 700",
                f_response_enable, bus_request_enable, bus_addr);
        end
        bus_response_enable = 1; bus_data = 32'h3;
        tick(); clr();
        checks++;
        if ({m_response_enable, busy} !== 2'b10 || m_data !== 32'h3) begin
            errors++; $display("FAIL rr_mem_resp got mr=%b busy=%b md=%h want 1 0 3", m_response_enable, busy, m_data);
        end
    endtask

    task automatic test_queued();
        int bad = 0;
        f_request_enable = 1; f_addr = 32'h800;
        tick(); clr(); tick();
        m_request_enable = 1; m_mode = 1; m_addr = 32'h900; m_wdata = 32'hCAFE; m_wstrb = 4'h3;
        tick(); clr();
        for (int i = 0; i < 3; i++) begin
            if (bus_request_enable !== 0 || busy !== 1) bad++;
            if (i < 2) tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL queued_wait got %0d bad cycles want 0", bad);
        end
        bus_response_enable = 1; bus_data = 32'h8;
        tick(); clr();
        checks++;
        if ({f_response_enable, bus_request_enable, busy, bus_mode} !== 4'b1111 ||
            bus_addr !== 32'h900 || bus_wstrb !== 4'h3) begin
            errors++; $display("FAIL queued_issue got fr=%b req=%b busy=%b mode=%b addr=%h st=%h want 1 1 1 1 900 3",
                f_response_enable, bus_request_enable, busy, bus_mode, bus_addr, bus_wstrb);
        end
        bus_response_enable = 1; bus_data = 32'h9;
        tick(); clr();
        checks++;
        if ({m_response_enable, busy} !== 2'b10 || m_data !== 32'h9) begin
            errors++; $display("FAIL queued_resp got mr=%b busy=%b md=%h want 1 0 9", m_response_enable, busy, m_data);
        end
    endtask

    task automatic test_reset_mid();
        f_request_enable = 1; f_addr = 32'hA00;
        tick(); clr(); tick();
        rstn = 0;
        tick(); rstn = 1;
        bus_response_enable = 1; bus_data = 32'h55;
        tick(); clr();
        checks++;
        if ({f_response_enable, m_response_enable, busy, bus_request_enable} !== 4'b0 ||
            f_data !== 0 || m_data !== 0 || bus_addr !== 0) begin
            errors++; $display("FAIL reset_mid got fr=%b mr=%b busy=%b req=%b fd=%h md=%h addr=%h want all 0",
                f_response_enable, m_response_enable, busy, bus_request_enable, f_data, m_data, bus_addr);
        end
    endtask

    task automatic test_owner_rereq();
        f_request_enable = 1; f_addr = 32'h3FFC;
        tick(); clr(); tick();
        bus_response_enable = 1; bus_data = 32'hAAAA; f_request_enable = 1; f_addr = 32'h4000;
        tick(); clr();
        checks++;
        if ({f_response_enable, bus_request_enable, busy} !== 3'b111 ||
            bus_addr !== 32'h4000 || f_data !== 32'hAAAA) begin
            errors++; $display("FAIL rereq_issue got fr=%b req=%b busy=%b addr=%h fd=%h want 1 1 1 4000 aaaa",
                f_response_enable, bus_request_enable, busy, bus_addr, f_data);
        end
        bus_response_enable = 1; bus_data = 32'hBBBB;
        tick(); clr();
        checks++;
        if ({f_response_enable, busy} !== 2'b10 || f_data !== 32'hBBBB) begin
            errors++; $display("FAIL rereq_resp got fr=%b busy=%b fd=%h want 1 0 bbbb", f_response_enable, busy, f_data);
        end
    endtask

    task automatic test_random();
        logic [138:0] got, want;
        for (int n = 0; n < 400; n++) begin
            // Requesters respect the protocol: at most one request in flight per port,
            // except a re-request on the edge the owner's response lands.
            bus_response_enable = (own >= 0) && ($urandom_range(0, 9) < 4);
            bus_data = $urandom;
            f_request_enable = !fpend && (own != 0 || bus_response_enable) && ($urandom_range(0, 2) == 0);
            m_request_enable = !mpend && (own != 1 || bus_response_enable) && ($urandom_range(0, 2) == 0);
            f_addr = $urandom; m_addr = $urandom; m_wdata = $urandom;
            m_mode = 1'($urandom); m_wstrb = 4'($urandom);
            tick();
            got  = {bus_request_enable, busy, f_response_enable, m_response_enable, bus_mode,
                    bus_addr, bus_wdata, bus_wstrb, f_data, m_data};
            want = {exp_breq, exp_busy, exp_fr, exp_mr, exp_bmode,
                    exp_baddr, exp_bwdata, exp_bwstrb, exp_fdata, exp_mdata};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL random cycle %0d got %h want %h", n, got, want);
            end
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_round_robin();
        test_queued();
        test_reset_mid();
        test_owner_rereq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
